// File: rtl/uart_dmi_pkg.sv
// Shared types and encodings for the UART-to-DMI command deframer.
package uart_dmi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_ISSUE
  } state_e;

  localparam logic [7:0] CMD_READ     = 8'h01;
  localparam logic [7:0] CMD_WRITE    = 8'h02;

  localparam logic [1:0] DMI_OP_READ  = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE = 2'd2;

  function automatic logic cmd_valid(input logic [7:0] b);
    return (b == CMD_READ) || (b == CMD_WRITE);
  endfunction

endpackage

// File: rtl/uart_dmi_deframer.sv
// Assembles UART command bytes into DMI read/write requests with a valid/ready
// handshake; flags bad opcodes, inter-byte timeouts and overruns.
module uart_dmi_deframer
  import uart_dmi_pkg::*;
#(
  parameter int unsigned CLK_RATE      = 100 * 10**6,
  parameter int unsigned BAUD_RATE     = 115200,
  parameter int unsigned TIMEOUT_BYTES = 4,
  parameter int unsigned ADDR_WIDTH    = 7,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                  CLK_I,
  input  logic                  RST_NI,
  input  logic                  RX_DONE_I,
  input  logic [7:0]            DATA_I,
  output logic                  REQ_VALID_O,
  input  logic                  REQ_READY_I,
  output logic [1:0]            REQ_OP_O,
  output logic [ADDR_WIDTH-1:0] REQ_ADDR_O,
  output logic [DATA_WIDTH-1:0] REQ_DATA_O,
  output logic                  ERR_OPCODE_O,
  output logic                  ERR_TIMEOUT_O,
  output logic                  ERR_OVERRUN_O
);

  localparam int unsigned TMO   = TIMEOUT_BYTES * 10 * (CLK_RATE / BAUD_RATE);
  localparam int unsigned CNT_W = $clog2(TMO + 1);
  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TMO);

  state_e                state, state_next;
  logic [CNT_W-1:0]      tmo_cnt;
  logic [1:0]            idx;
  logic [1:0]            op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  err_opcode_q, err_timeout_q, err_overrun_q;

  logic in_frame, tmo_hit, take_cmd;
  logic err_opcode_d, err_timeout_d, err_overrun_d;

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next    = state;
    take_cmd      = 1'b0;
    err_opcode_d  = 1'b0;
    err_timeout_d = 1'b0;
    err_overrun_d = 1'b0;
    in_frame      = (state == ST_ADDR) || (state == ST_DATA);
    // A strobe landing on the expiry cycle wins over the timeout.
    tmo_hit       = in_frame && !RX_DONE_I && (tmo_cnt == TMO_CNT);

    case (state)
      ST_IDLE:  take_cmd = RX_DONE_I;
      ST_ADDR:  if (RX_DONE_I) state_next = (op_q == DMI_OP_READ) ? ST_ISSUE : ST_DATA;
      ST_DATA:  if (RX_DONE_I && idx == 2'd3) state_next = ST_ISSUE;
      ST_ISSUE: begin
        if (REQ_READY_I) begin
          state_next = ST_IDLE;
          take_cmd   = RX_DONE_I;
        end else begin
          err_overrun_d = RX_DONE_I;
        end
      end
      default:  state_next = ST_IDLE;
    endcase

    if (take_cmd) begin
      if (cmd_valid(DATA_I)) state_next   = ST_ADDR;
      else                   err_opcode_d = 1'b1;
    end

    if (tmo_hit) begin
      state_next    = ST_IDLE;
      err_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      tmo_cnt       <= '0;
      idx           <= '0;
      op_q          <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      err_opcode_q  <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      err_opcode_q  <= err_opcode_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;

      if (!in_frame || RX_DONE_I || tmo_hit) tmo_cnt <= '0;
      else                                   tmo_cnt <= tmo_cnt + CNT_W'(1);

      if (take_cmd && cmd_valid(DATA_I))
        op_q <= (DATA_I == CMD_READ) ? DMI_OP_READ : DMI_OP_WRITE;

      if (state == ST_ADDR && RX_DONE_I) begin
        addr_q <= DATA_I[ADDR_WIDTH-1:0];
        if (op_q == DMI_OP_READ) data_q <= '0;
        else                     idx    <= '0;
      end

      if (state == ST_DATA && RX_DONE_I) begin
        data_q[{idx, 3'b000} +: 8] <= DATA_I;
        idx                        <= idx + 2'd1;
      end
    end
  end

  assign REQ_VALID_O   = (state == ST_ISSUE);
  assign REQ_OP_O      = op_q;
  assign REQ_ADDR_O    = addr_q;
  assign REQ_DATA_O    = data_q;
  assign ERR_OPCODE_O  = err_opcode_q;
  assign ERR_TIMEOUT_O = err_timeout_q;
  assign ERR_OVERRUN_O = err_overrun_q;

endmodule

// File: tb/tb_uart_dmi_deframer.sv
// Directed and randomized checks of uart_dmi_deframer against frame-level expectations.
module tb_uart_dmi_deframer;

  localparam int unsigned BAUD   = 115200;
  localparam int unsigned CLK_HZ = 4 * BAUD;
  localparam int unsigned TBYTES = 4;
  localparam int unsigned AW     = 7;
  localparam int unsigned DW     = 32;
  localparam int unsigned TMO    = TBYTES * 10 * (CLK_HZ / BAUD);

  logic          clk = 1'b0;
  logic          rst_n, rx_done, ready;
  logic [7:0]    din;
  logic          req_valid;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          err_opcode, err_timeout, err_overrun;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_dmi_deframer #(
    .CLK_RATE     (CLK_HZ),
    .BAUD_RATE    (BAUD),
    .TIMEOUT_BYTES(TBYTES),
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW)
  ) dut (
    .CLK_I        (clk),
    .RST_NI       (rst_n),
    .RX_DONE_I    (rx_done),
    .DATA_I       (din),
    .REQ_VALID_O  (req_valid),
    .REQ_READY_I  (ready),
    .REQ_OP_O     (req_op),
    .REQ_ADDR_O   (req_addr),
    .REQ_DATA_O   (req_data),
    .ERR_OPCODE_O (err_opcode),
    .ERR_TIMEOUT_O(err_timeout),
    .ERR_OVERRUN_O(err_overrun)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    din     = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic expect_zero(input string tag);
    check({tag, "_valid"}, 64'(req_valid),   64'd0);
    check({tag, "_op"},    64'(req_op),      64'd0);
    check({tag, "_addr"},  64'(req_addr),    64'd0);
    check({tag, "_data"},  64'(req_data),    64'd0);
    check({tag, "_eop"},   64'(err_opcode),  64'd0);
    check({tag, "_etmo"},  64'(err_timeout), 64'd0);
    check({tag, "_eovr"},  64'(err_overrun), 64'd0);
  endtask

  task automatic expect_req(input string tag, input logic [1:0] op,
                            input logic [AW-1:0] addr, input logic [DW-1:0] dat);
    check({tag, "_valid"}, 64'(req_valid), 64'd1);
    check({tag, "_op"},    64'(req_op),    64'(op));
    check({tag, "_addr"},  64'(req_addr),  64'(addr));
    check({tag, "_data"},  64'(req_data),  64'(dat));
  endtask

  // Holds ready low for 'hold' cycles (optionally firing stray bytes), then completes the handshake.
  task automatic complete_req(input string tag, input logic [1:0] op, input logic [AW-1:0] addr,
                              input logic [DW-1:0] dat, input int unsigned hold, input bit strays);
    ready = 1'b0;
    for (int unsigned k = 0; k < hold; k++) begin
      if (strays && $urandom_range(0, 2) == 0) begin
        send_byte(8'($urandom_range(0, 255)));
        check({tag, "_ovr_pulse"}, 64'(err_overrun), 64'd1);
      end else begin
        tick();
        check({tag, "_ovr_quiet"}, 64'(err_overrun), 64'd0);
      end
      expect_req({tag, "_hold"}, op, addr, dat);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check({tag, "_drop"},     64'(req_valid),   64'd0);
    check({tag, "_drop_ovr"}, 64'(err_overrun), 64'd0);
  endtask

  task automatic send_frame(input string tag, input logic [7:0] fb [6],
                            input int unsigned n, input bit long_gaps);
    int unsigned gap;
    for (int unsigned i = 0; i < n; i++) begin
      if (i > 0) begin
        gap = 0;
        if (long_gaps) gap = ($urandom_range(0, 9) == 0) ? TMO : $urandom_range(0, 4);
        idle(gap);
      end
      send_byte(fb[i]);
      check({tag, "_no_tmo"}, 64'(err_timeout), 64'd0);
      if (i < n - 1) check({tag, "_early_valid"}, 64'(req_valid), 64'd0);
    end
  endtask

  initial begin
    logic [7:0]    fb [6];
    logic [7:0]    bad;
    bit            wr;
    int unsigned   a_int, word;
    logic [1:0]    exp_op;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;

    rst_n = 1'b0; rx_done = 1'b0; ready = 1'b0; din = 8'h00;
    idle(3);
    expect_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // READ with a long ready-low stall.
    send_byte(8'h01);
    check("rd_after_cmd", 64'(req_valid), 64'd0);
    send_byte(8'h05);
    expect_req("rd", 2'd1, 7'h05, 32'h0);
    complete_req("rd", 2'd1, 7'h05, 32'h0, 20, 1'b0);

    // WRITE then back-to-back READ.
    fb = '{8'h02, 8'h10, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_frame("wr", fb, 6, 1'b0);
    expect_req("wr", 2'd2, 7'h10, 32'hDEADBEEF);
    complete_req("wr", 2'd2, 7'h10, 32'hDEADBEEF, 2, 1'b0);
    send_byte(8'h01);
    send_byte(8'h22);
    expect_req("b2b_rd", 2'd1, 7'h22, 32'h0);
    complete_req("b2b_rd", 2'd1, 7'h22, 32'h0, 0, 1'b0);

    // Invalid command.
    send_byte(8'h7F);
    check("badcmd_pulse", 64'(err_opcode), 64'd1);
    tick();
    check("badcmd_end", 64'(err_opcode), 64'd0);
    send_byte(8'h01);
    check("badcmd_idle", 64'(req_valid), 64'd0);
    send_byte(8'h03);
    expect_req("badcmd_rd", 2'd1, 7'h03, 32'h0);
    complete_req("badcmd_rd", 2'd1, 7'h03, 32'h0, 1, 1'b0);

    // Timeout in DATA: pulse appears exactly TMO+1 cycles after the last strobe.
    send_byte(8'h02); send_byte(8'h10); send_byte(8'h11);
    idle(TMO);
    check("tmo_before", 64'(err_timeout), 64'd0);
    tick();
    check("tmo_pulse", 64'(err_timeout), 64'd1);
    check("tmo_novalid", 64'(req_valid), 64'd0);
    tick();
    check("tmo_end", 64'(err_timeout), 64'd0);
    fb = '{8'h02, 8'h33, 8'h78, 8'h56, 8'h34, 8'h12};
    send_frame("tmo_recover", fb, 6, 1'b0);
    expect_req("tmo_recover", 2'd2, 7'h33, 32'h12345678);
    complete_req("tmo_recover", 2'd2, 7'h33, 32'h12345678, 0, 1'b0);

    // Timeout in ADDR.
    send_byte(8'h01);
    idle(TMO + 1);
    check("tmo_addr_pulse", 64'(err_timeout), 64'd1);
    check("tmo_addr_novalid", 64'(req_valid), 64'd0);

    // Every byte arrives on the expiry cycle: bytes win.
    send_byte(8'h02);
    foreach (fb[i]) fb[i] = 8'(8'h40 + i);
    for (int i = 1; i < 6; i++) begin
      idle(TMO);
      send_byte(fb[i]);
      check("edge_no_tmo", 64'(err_timeout), 64'd0);
    end
    expect_req("edge", 2'd2, 7'h41, 32'h45444342);
    complete_req("edge", 2'd2, 7'h41, 32'h45444342, 0, 1'b0);

    // Overrun while pending, then a command byte coinciding with the handshake.
    send_byte(8'h01);
    send_byte(8'h07);
    send_byte(8'h01);
    check("ovr_pulse", 64'(err_overrun), 64'd1);
    expect_req("ovr_held", 2'd1, 7'h07, 32'h0);
    tick();
    check("ovr_end", 64'(err_overrun), 64'd0);
    ready = 1'b1; din = 8'h01; rx_done = 1'b1;
    tick();
    ready = 1'b0; rx_done = 1'b0;
    check("hs_byte_valid", 64'(req_valid), 64'd0);
    check("hs_byte_ovr", 64'(err_overrun), 64'd0);
    check("hs_byte_eop", 64'(err_opcode), 64'd0);
    send_byte(8'h09);
    expect_req("hs_byte_rd", 2'd1, 7'h09, 32'h0);
    complete_req("hs_byte_rd", 2'd1, 7'h09, 32'h0, 0, 1'b0);

    // Asynchronous reset mid-WRITE.
    send_byte(8'h02); send_byte(8'h10); send_byte(8'hEF);
    check("pre_rst_op", 64'(req_op), 64'd2);
    #3 rst_n = 1'b0;
    #1;
    expect_zero("async_rst");
    tick();
    rst_n = 1'b1;
    tick();
    send_byte(8'h01);
    send_byte(8'h7E);
    expect_req("post_rst", 2'd1, 7'h7E, 32'h0);
    complete_req("post_rst", 2'd1, 7'h7E, 32'h0, 1, 1'b0);

    // Randomized frames against the frame-level model.
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        bad = 8'($urandom_range(0, 255));
        while (bad == 8'h01 || bad == 8'h02) bad = 8'($urandom_range(0, 255));
        send_byte(bad);
        check("rnd_badcmd", 64'(err_opcode), 64'd1);
        tick();
      end
      wr = 1'($urandom_range(0, 1));
      foreach (fb[i]) fb[i] = 8'($urandom_range(0, 255));
      fb[0]    = wr ? 8'h02 : 8'h01;
      a_int    = fb[1];
      word     = fb[2] + fb[3] * 256 + fb[4] * 65536 + fb[5] * 16777216;
      exp_op   = wr ? 2'd2 : 2'd1;
      exp_addr = AW'(a_int % (1 << AW));
      exp_data = wr ? DW'(word) : '0;
      send_frame("rnd", fb, wr ? 6 : 2, 1'b1);
      expect_req("rnd", exp_op, exp_addr, exp_data);
      complete_req("rnd", exp_op, exp_addr, exp_data, $urandom_range(0, 6), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_dmi_deframer.md
Name: uart_dmi_deframer

Overview:
Byte-level command deframer that sits directly downstream of the debug UART receiver. It consumes the receiver's byte strobe and data byte, assembles multi-byte command frames into DMI requests, and presents them to the DMI side over a valid/ready handshake. It detects and reports unknown opcodes, inter-byte timeouts and overruns, because the UART cannot be back-pressured.

Parameters:
CLK_RATE, 100*10**6, system clock frequency in Hz.
BAUD_RATE, 115200, UART line rate in baud.
TIMEOUT_BYTES, 4, inter-byte timeout expressed in byte times (10 bits each).
ADDR_WIDTH, 7, DMI address width.
DATA_WIDTH, 32, DMI data width; must be 32 (4 payload bytes).

Ports:
CLK_I  input  1  system clock; all logic is on the rising edge.
RST_NI  input  1  reset, asynchronous, active-low.
RX_DONE_I  input  1  single-cycle strobe from the UART receiver: DATA_I is valid.
DATA_I  input  8  received byte.
REQ_VALID_O  output  1  DMI request valid.
REQ_READY_I  input  1  DMI side accepts the request.
REQ_OP_O  output  2  DMI op: 1 = read, 2 = write.
REQ_ADDR_O  output  ADDR_WIDTH  DMI address.
REQ_DATA_O  output  DATA_WIDTH  write data; 0 for reads.
ERR_OPCODE_O  output  1  1-cycle pulse: invalid command byte.
ERR_TIMEOUT_O  output  1  1-cycle pulse: frame abandoned on timeout.
ERR_OVERRUN_O  output  1  1-cycle pulse: byte dropped while a request was pending.

Behaviour:
- Reset, asynchronous: state = IDLE. All outputs are 0. The timeout counter and the byte index are 0.
- Frame format:
  - Byte 0 is CMD. 0x01 = READ, 0x02 = WRITE. Any other value is invalid.
  - Byte 1 is ADDR. ADDR_WIDTH LSBs are used; bit 7 is ignored.
  - WRITE only: bytes 2..5 are data, little-endian. Byte 2 goes to bits [7:0].
- States: IDLE, ADDR, DATA, ISSUE.
  - IDLE, on RX_DONE_I:
    - CMD 0x01 or 0x02: latch the op, go to ADDR.
    - Any other CMD: pulse ERR_OPCODE_O the next cycle, stay in IDLE.
  - ADDR, on RX_DONE_I: latch the address.
    - READ: clear the data register, go to ISSUE.
    - WRITE: clear the byte index, go to DATA.
  - DATA, on RX_DONE_I: write the byte into lane [index]. Increment the index. The byte at index 3 moves to ISSUE.
  - ISSUE: REQ_VALID_O = 1. When REQ_VALID_O and REQ_READY_I are both high, go to IDLE.
- Latency: REQ_VALID_O rises the cycle after the RX_DONE_I of the final frame byte.
- Handshake:
  - REQ_OP_O, REQ_ADDR_O and REQ_DATA_O are registered and stable while REQ_VALID_O is high.
  - REQ_VALID_O never drops without a handshake.
  - REQ_READY_I is ignored outside ISSUE.
- Timeout:
  - Limit TMO = TIMEOUT_BYTES*10*(CLK_RATE/BAUD_RATE) cycles. The counter width is $clog2(TMO+1).
  - The counter runs only in ADDR and DATA and reloads to 0 on every RX_DONE_I.
  - On reaching TMO: pulse ERR_TIMEOUT_O, discard the partial frame, go to IDLE.
- Simultaneous events:
  - RX_DONE_I in the same cycle the timeout expires: the byte wins. It is consumed and the counter reloads; no error.
  - ISSUE with RX_DONE_I and no handshake: the byte is dropped, ERR_OVERRUN_O pulses, the request is held unchanged.
  - ISSUE with RX_DONE_I and a handshake in the same cycle: the request completes. The byte is treated as a new CMD byte, evaluated as in IDLE. No overrun.
- Error pulses are registered, exactly 1 cycle long, and mutually independent.
- Reset asserted mid-frame or mid-ISSUE: everything clears immediately and the request is lost.

Decomposition:
- Package uart_dmi_pkg holds:
  - the state enum;
  - CMD_READ = 8'h01 and CMD_WRITE = 8'h02;
  - the DMI op encodings: DMI_OP_READ = 2'd1, DMI_OP_WRITE = 2'd2.
- No sub-module. The timeout counter stays inline.

Test Plan:
1. READ: bytes 0x01, 0x05 -> REQ_VALID_O=1 one cycle after the 2nd strobe, OP=1, ADDR=0x05, DATA=0. Hold ready low 20 cycles, then high 1 cycle -> outputs stable throughout, REQ_VALID_O falls after the handshake.
2. WRITE: 0x02, 0x10, 0xEF, 0xBE, 0xAD, 0xDE -> OP=2, ADDR=0x10, DATA=0xDEADBEEF. A back-to-back READ after the handshake also decodes correctly.
3. Invalid CMD 0x7F -> one ERR_OPCODE_O pulse, state stays IDLE. A following 0x01, 0x03 yields READ at ADDR 0x03.
4. Timeout: send 0x02, 0x10, 0x11, then silence for more than TMO cycles -> one ERR_TIMEOUT_O pulse, no REQ_VALID_O. A later valid frame decodes normally. Also strobe a byte exactly on cycle TMO -> no error.
5. Overrun: with a READ pending and ready low, strobe 0x01 -> ERR_OVERRUN_O pulse, request unchanged. Strobe 0x01 in the same cycle as the handshake -> no overrun, state = ADDR.
6. Assert reset mid-WRITE, after 3 bytes -> all outputs 0 asynchronously. After release, a full READ frame works.
